// File: rtl/lcd_pio_driver.sv
// lcd_pio_driver: turns each toggled PIO command word into one timed
// HD44780-style write cycle on the 16x2 character LCD. A fixed power-up
// initialisation sequence runs after every reset. cmd_word shares the clock
// of this block, so it is sampled directly without a synchroniser.
module lcd_pio_driver #(
  parameter int PWRUP_CYC    = 750000,
  parameter int SETUP_CYC    = 2,
  parameter int EN_CYC       = 12,
  parameter int HOLD_CYC     = 2,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cmd_word,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on,
  output logic        busy,
  output logic        ready
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max_of(max_of(max_of(PWRUP_CYC, SETUP_CYC),
                                         max_of(EN_CYC, HOLD_CYC)),
                                  max_of(CMD_WAIT_CYC, CLR_WAIT_CYC));
  localparam int CW = $clog2(MAX_CYC + 1);

  // Counter load values: a state lasting N cycles starts at N-1 and exits at 0.
  localparam logic [CW-1:0] PWRUP_LD = CW'(PWRUP_CYC - 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] CMD_LD   = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLR_LD   = CW'(CLR_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_POWERUP,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_val;
  logic          cnt_load;
  logic          cnt_done;
  logic [1:0]    init_idx_q, init_idx_d;
  logic          init_load;
  logic          take_cmd;
  logic          last_tog_q;
  logic [7:0]    cur_byte_q;
  logic          cur_rs_q;
  logic          long_wait;

  // Bits [31:10] of the PIO word carry nothing for this block.
  logic unused_bits;
  assign unused_bits = ^cmd_word[31:10];

  // Write-only interface: the LCD busy flag is never read back.
  assign lcd_rw = 1'b0;

  // Power-up initialisation bytes, all sent with RS=0.
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;  // 8-bit bus, 2 lines, 5x8 font
      2'd1:    return 8'h0C;  // display on, cursor off
      2'd2:    return 8'h01;  // clear display
      default: return 8'h06;  // entry mode: increment, no shift
    endcase
  endfunction

  assign cnt_done  = (cnt_q == '0);
  // Clear and home need the long post-write wait.
  assign long_wait = !cur_rs_q && ((cur_byte_q == 8'h01) || (cur_byte_q == 8'h02));

  // Next-state, counter-load and latch-enable decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    init_load  = 1'b0;
    init_idx_d = init_idx_q;
    take_cmd   = 1'b0;
    case (state_q)
      S_POWERUP: begin
        if (cnt_done) begin
          state_d    = S_SETUP;
          cnt_load   = 1'b1;
          cnt_val    = SETUP_LD;
          init_load  = 1'b1;
          init_idx_d = 2'd0;
        end
      end
      S_IDLE: begin
        if (cmd_word[9] != last_tog_q) begin
          state_d  = S_SETUP;
          cnt_load = 1'b1;
          cnt_val  = SETUP_LD;
          take_cmd = 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt_done) begin
          state_d  = S_PULSE;
          cnt_load = 1'b1;
          cnt_val  = EN_LD;
        end
      end
      S_PULSE: begin
        if (cnt_done) begin
          state_d  = S_HOLD;
          cnt_load = 1'b1;
          cnt_val  = HOLD_LD;
        end
      end
      S_HOLD: begin
        if (cnt_done) begin
          state_d  = S_WAIT;
          cnt_load = 1'b1;
          cnt_val  = long_wait ? CLR_LD : CMD_LD;
        end
      end
      S_WAIT: begin
        if (cnt_done) begin
          cnt_load = 1'b1;
          // During init, chain straight into the next byte without an IDLE cycle.
          if (!ready && (init_idx_q != 2'd3)) begin
            state_d    = S_SETUP;
            cnt_val    = SETUP_LD;
            init_load  = 1'b1;
            init_idx_d = init_idx_q + 2'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_POWERUP;
    endcase
  end

  // State register and the single shared down-counter.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of its neighbours, whatever the statement order.
    if (reset) begin
      state_q <= S_POWERUP;
      cnt_q   <= PWRUP_LD;
    end else begin
      state_q <= state_d;
      if (cnt_load) begin
        cnt_q <= cnt_val;
      end else if (!cnt_done) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Command latch: host word on a toggle in IDLE, ROM byte during init.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: every control register here has a reset value; the LCD must see
    // a quiet bus and the init sequence must restart cleanly after reset.
    if (reset) begin
      last_tog_q <= 1'b0;
      cur_byte_q <= 8'h00;
      cur_rs_q   <= 1'b0;
      init_idx_q <= 2'd0;
    end else begin
      if (take_cmd) begin
        last_tog_q <= cmd_word[9];
        cur_byte_q <= cmd_word[7:0];
        cur_rs_q   <= cmd_word[8];
      end else if (init_load) begin
        cur_byte_q <= init_byte(init_idx_d);
        cur_rs_q   <= 1'b0;
      end
      if (init_load) begin
        init_idx_q <= init_idx_d;
      end
    end
  end

  // Registered pin drivers, one cycle behind the state so the pins are glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_on   <= 1'b0;
      busy     <= 1'b1;
      ready    <= 1'b0;
    end else begin
      // Bus is driven during SETUP and then simply held until the next SETUP.
      if (state_q == S_SETUP) begin
        lcd_data <= cur_byte_q;
        lcd_rs   <= cur_rs_q;
      end
      lcd_en <= (state_q == S_PULSE);
      lcd_on <= 1'b1;
      busy   <= (state_q != S_IDLE);
      // IDLE is only reachable once init has finished, so this is sticky.
      ready  <= ready | (state_q == S_IDLE);
    end
  end

endmodule

// File: tb/tb_lcd_pio_driver.sv
// tb_lcd_pio_driver: scoreboard bench for lcd_pio_driver with short timing
// parameters. Expected pulses and busy lengths are queued as stimulus is
// driven; a negedge monitor pops and compares them and watches bus stability.
module tb_lcd_pio_driver;

  localparam int PWRUP = 20;
  localparam int SETUP = 2;
  localparam int EN    = 3;
  localparam int HOLD  = 2;
  localparam int CMDW  = 5;
  localparam int CLRW  = 10;

  localparam int L_CMD = SETUP + EN + HOLD + CMDW;   // 12
  localparam int L_CLR = SETUP + EN + HOLD + CLRW;   // 17
  localparam int INIT_BUSY = PWRUP + 3 * L_CMD + L_CLR;
  // POWERUP ends at the PWRUP-th edge, which then behaves like a toggle seen
  // at edge t: EN rises at edge t+1+SETUP.
  localparam int FIRST_EN = PWRUP + SETUP + 1;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } pulse_t;

  logic        clk;
  logic        reset;
  logic [31:0] cmd_word;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on, busy, ready;

  int checks = 0;
  int errors = 0;

  pulse_t exp_q[$];
  int     busy_q[$];
  int     rise_log[$];

  lcd_pio_driver #(
    .PWRUP_CYC(PWRUP), .SETUP_CYC(SETUP), .EN_CYC(EN),
    .HOLD_CYC(HOLD), .CMD_WAIT_CYC(CMDW), .CLR_WAIT_CYC(CLRW)
  ) dut (
    .clk(clk), .reset(reset), .cmd_word(cmd_word),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_en(lcd_en), .lcd_on(lcd_on), .busy(busy), .ready(ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Negedge monitor: scoreboard pops, EN width, busy length, bus stability.
  initial begin
    int     cyc = 0, busy_run = 0, en_run = 0, hold_left = 0;
    logic   prev_en = 1'b0, prev_busy = 1'b1, prev_rs = 1'b0;
    logic [7:0] prev_data = 8'h00;
    pulse_t p;
    int     bl;
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc = 0; busy_run = 0; en_run = 0; hold_left = 0;
        prev_en = 1'b0; prev_busy = 1'b1;
        prev_data = lcd_data; prev_rs = lcd_rs;
      end else begin
        cyc++;
        check("rw_low", lcd_rw, 1'b0);
        if (lcd_en || hold_left > 0)
          check("bus_stable", {lcd_rs, lcd_data}, {prev_rs, prev_data});
        if (lcd_en) hold_left = HOLD;
        else if (hold_left > 0) hold_left--;
        if (lcd_en && !prev_en) begin
          rise_log.push_back(cyc);
          check("pulse_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            p = exp_q.pop_front();
            check("pulse_data", lcd_data, p.data);
            check("pulse_rs", lcd_rs, p.rs);
          end
        end
        if (lcd_en) en_run++;
        else if (prev_en) begin
          check("en_width", en_run, EN);
          en_run = 0;
        end
        if (busy) busy_run++;
        else if (prev_busy) begin
          check("busy_expected", busy_q.size() > 0, 1'b1);
          if (busy_q.size() > 0) begin
            bl = busy_q.pop_front();
            check("busy_len", busy_run, bl);
          end
          busy_run = 0;
        end
        prev_en = lcd_en; prev_busy = busy;
        prev_data = lcd_data; prev_rs = lcd_rs;
      end
    end
  end

  // Bounded wait at negedges until busy reaches val.
  task automatic wait_busy(input logic val, input int budget, input string tag);
    int n = 0;
    while (busy !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== val) check(tag, busy, val);
  endtask

  // Drive a host word (caller is at a negedge with the DUT idle) and wait it out.
  task automatic run_cmd(input logic [31:0] word, input int len);
    exp_q.push_back('{rs: word[8], data: word[7:0]});
    busy_q.push_back(len);
    cmd_word = word;
    wait_busy(1'b1, 10, "cmd_start_timeout");
    wait_busy(1'b0, 100, "cmd_end_timeout");
  endtask

  // Release reset and follow the whole init sequence.
  task automatic release_and_init();
    int   n = 0;
    logic ready_before = 1'b1;
    rise_log.delete();
    exp_q.push_back('{rs: 1'b0, data: 8'h38});
    exp_q.push_back('{rs: 1'b0, data: 8'h0C});
    exp_q.push_back('{rs: 1'b0, data: 8'h01});
    exp_q.push_back('{rs: 1'b0, data: 8'h06});
    busy_q.push_back(INIT_BUSY);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("lcd_on_after_release", lcd_on, 1'b1);
    while (busy === 1'b1 && n < 300) begin
      ready_before = ready;
      @(negedge clk);
      n++;
    end
    check("init_done", busy, 1'b0);
    check("ready_low_during_init", ready_before, 1'b0);
    check("ready_at_busy_fall", ready, 1'b1);
    check("init_pulse_count", rise_log.size(), 4);
    if (rise_log.size() == 4) begin
      check("first_en_time", rise_log[0], FIRST_EN);
      check("gap_after_38", rise_log[1] - rise_log[0], L_CMD);
      check("gap_after_0c", rise_log[2] - rise_log[1], L_CMD);
      check("gap_after_01", rise_log[3] - rise_log[2], L_CLR);
    end
  endtask

  initial begin
    reset    = 1'b1;
    cmd_word = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_data", lcd_data, 8'h00);
    check("rst_rs", lcd_rs, 1'b0);
    check("rst_en", lcd_en, 1'b0);
    check("rst_on", lcd_on, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_ready", ready, 1'b0);

    // Scenario 1: power-up init.
    release_and_init();

    // Scenario 2: single host write, then holding the word must not repeat it.
    run_cmd(32'h0000_0241, L_CMD);
    repeat (30) @(negedge clk);
    check("no_repeat_busy", busy, 1'b0);
    check("no_repeat_queue", exp_q.size(), 0);

    // Scenario 3: data write with RS=1, then clear with the long wait.
    run_cmd(32'h0000_0141, L_CMD);
    run_cmd(32'h0000_0201, L_CLR);

    // Scenario 4: toggles while busy; latest word wins, even toggle count is silent.
    run_cmd_overlap();
    repeat (30) @(negedge clk);
    check("even_toggle_busy", busy, 1'b0);
    check("even_toggle_queue", exp_q.size(), 0);
    check("ready_sticky", ready, 1'b1);

    // Scenario 5: reset while EN is high, then init reruns.
    exp_q.push_back('{rs: 1'b0, data: 8'h50});
    cmd_word = 32'h0000_0050;
    begin
      int n = 0;
      while (lcd_en !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("reach_en_high", lcd_en, 1'b1);
    end
    #1 reset = 1'b1;
    #1;
    check("async_en_drop", lcd_en, 1'b0);
    check("async_ready_drop", ready, 1'b0);
    check("async_busy", busy, 1'b1);
    check("async_on", lcd_on, 1'b0);
    check("async_data", lcd_data, 8'h00);
    repeat (3) @(negedge clk);
    release_and_init();

    repeat (20) @(negedge clk);
    check("final_pulse_queue", exp_q.size(), 0);
    check("final_busy_queue", busy_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Current command 0x43 (toggle 0); during it 0x241 then 0x242 flip the
  // toggle once net, so only 0x42 follows. During 0x42, 0x044 then 0x245
  // return the toggle to its accepted value, so nothing follows.
  task automatic run_cmd_overlap();
    exp_q.push_back('{rs: 1'b0, data: 8'h43});
    busy_q.push_back(L_CMD);
    cmd_word = 32'h0000_0043;
    wait_busy(1'b1, 10, "ovl_start_timeout");
    @(negedge clk);
    cmd_word = 32'h0000_0241;
    @(negedge clk);
    cmd_word = 32'h0000_0242;
    exp_q.push_back('{rs: 1'b0, data: 8'h42});
    busy_q.push_back(L_CMD);
    wait_busy(1'b0, 100, "ovl_first_end_timeout");
    wait_busy(1'b1, 10, "ovl_second_start_timeout");
    @(negedge clk);
    cmd_word = 32'h0000_0044;
    @(negedge clk);
    cmd_word = 32'h0000_0245;
    wait_busy(1'b0, 100, "ovl_second_end_timeout");
  endtask

endmodule
